// File: rtl/rob_commit.sv
// rob_commit: reorder buffer on the receiving side of the FXU completion path.
// Entries are allocated in program order at dispatch. Writebacks may arrive
// out of order and are captured by index. Completed entries retire in order
// to the register file, at most one per cycle, through registered outputs.
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_reg,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_index,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              flush,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_value,
  output logic [IDX_W:0]    count,
  output logic              wb_err
);

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Pointer / occupancy state
  logic [IDX_W-1:0]  head_reg, tail_reg;
  logic [IDX_W:0]    count_reg, count_next;

  // Per-entry status flags (reset) and payload storage (not reset)
  logic [DEPTH-1:0]  busy_reg, busy_next;
  logic [DEPTH-1:0]  done_reg, done_next;
  logic [REG_W-1:0]  reg_mem [DEPTH];
  logic [DATA_W-1:0] val_mem [DEPTH];

  // Registered commit outputs and sticky error
  logic              commit_valid_reg;
  logic [REG_W-1:0]  commit_reg_reg;
  logic [DATA_W-1:0] commit_value_reg;
  logic              wb_err_reg;

  // Event qualifiers for this edge; a flush suppresses every other event
  logic do_alloc, do_retire, do_wb, wb_legal, wb_bad;

  // Readiness depends only on the current occupancy, so a full buffer cannot
  // reuse the slot that a same-edge retirement frees.
  assign alloc_ready = (count_reg != CNT_FULL);
  assign alloc_index = tail_reg;

  assign do_alloc  = alloc_valid && alloc_ready && !flush;
  // Retirement looks only at registered done flags: a writeback landing on the
  // head this edge becomes visible for retirement on the following edge.
  assign do_retire = (count_reg != '0) && busy_reg[head_reg] && done_reg[head_reg] && !flush;
  assign wb_legal  = busy_reg[wb_index] && !done_reg[wb_index];
  assign do_wb     = wb_valid && wb_legal && !flush;
  assign wb_bad    = wb_valid && !wb_legal && !flush;

  // Occupancy follows the alloc/retire pair; both together leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({do_alloc, do_retire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Next-state flags per entry. Retire (head) and allocate (tail) never hit the
  // same entry, and a legal writeback never targets a free or done entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [IDX_W-1:0] ENTRY = IDX_W'(gi);
    logic hit_retire, hit_alloc, hit_wb;
    assign hit_retire = do_retire && (head_reg == ENTRY);
    assign hit_alloc  = do_alloc  && (tail_reg == ENTRY);
    assign hit_wb     = do_wb     && (wb_index == ENTRY);
    assign busy_next[gi] = hit_retire ? 1'b0 :
                           hit_alloc  ? 1'b1 : busy_reg[gi];
    assign done_next[gi] = hit_retire ? 1'b0 :
                           hit_alloc  ? 1'b0 :
                           hit_wb     ? 1'b1 : done_reg[gi];
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= '0;
      done_reg  <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= '0;
      done_reg  <= '0;
    end else begin
      if (do_retire) head_reg <= head_reg + IDX_ONE;
      if (do_alloc)  tail_reg <= tail_reg + IDX_ONE;
      count_reg <= count_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Payload storage: destination captured at allocation, value at writeback
  always_ff @(posedge clk) begin
    if (do_alloc) reg_mem[tail_reg] <= alloc_reg;
    if (do_wb)    val_mem[wb_index] <= wb_value;
  end

  // Registered retirement port; data holds its last value between commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_reg <= 1'b0;
      commit_reg_reg   <= '0;
      commit_value_reg <= '0;
    end else if (do_retire) begin
      commit_valid_reg <= 1'b1;
      commit_reg_reg   <= reg_mem[head_reg];
      commit_value_reg <= val_mem[head_reg];
    end else begin
      commit_valid_reg <= 1'b0;
    end
  end

  // Sticky flag for writebacks to free or already-completed entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err_reg <= 1'b0;
    end else if (wb_bad) begin
      wb_err_reg <= 1'b1;
    end
  end

  assign commit_valid = commit_valid_reg;
  assign commit_reg   = commit_reg_reg;
  assign commit_value = commit_value_reg;
  assign count        = count_reg;
  assign wb_err       = wb_err_reg;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and randomized stimulus for rob_commit. A program-
// order reference model predicts each retirement; predictions are queued and a
// separate monitor pops them whenever the DUT presents a commit.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_reg = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_index;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_index = '0;
  logic [15:0] wb_value = '0;
  logic        flush = 1'b0;
  logic        commit_valid;
  logic [3:0]  commit_reg;
  logic [15:0] commit_value;
  logic [4:0]  count;
  logic        wb_err;

  rob_commit #(.DEPTH(16), .IDX_W(4), .DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_value(wb_value),
    .flush(flush),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_value(commit_value),
    .count(count), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int v;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a ring of 16 slots described by head and occupancy
  bit m_busy[16];
  bit m_done[16];
  int m_reg[16];
  int m_val[16];
  int m_head;
  int m_count;
  bit m_err;

  function automatic int m_tail();
    return (m_head + m_count) % 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
    end
    m_head = 0;
    m_count = 0;
    m_err = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference model, decided from pre-edge state
  task automatic model_step(input bit av, input int ar, input bit wv,
                            input int wi, input int wd, input bit fl);
    bit ret, alc, wok;
    int slot;
    exp_t e;
    if (fl) begin
      for (int i = 0; i < 16; i++) begin
        m_busy[i] = 0;
        m_done[i] = 0;
      end
      m_head = 0;
      m_count = 0;
      return;
    end
    ret  = (m_count > 0) && m_busy[m_head] && m_done[m_head];
    alc  = av && (m_count != 16);
    wok  = wv && m_busy[wi] && !m_done[wi];
    slot = m_tail();
    if (wv && !wok) m_err = 1;
    if (ret) begin
      e.r = m_reg[m_head];
      e.v = m_val[m_head];
      exp_q.push_back(e);
      m_busy[m_head] = 0;
      m_done[m_head] = 0;
      m_head = (m_head + 1) % 16;
      m_count--;
    end
    if (alc) begin
      m_busy[slot] = 1;
      m_done[slot] = 0;
      m_reg[slot] = ar;
      m_count++;
    end
    if (wok) begin
      m_done[wi] = 1;
      m_val[wi] = wd;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at negedge, check current outputs, advance model
  task automatic cyc(input bit av, input int ar, input bit wv, input int wi,
                     input int wd, input bit fl);
    @(negedge clk);
    alloc_valid = av;
    alloc_reg   = 4'(ar);
    wb_valid    = wv;
    wb_index    = 4'(wi);
    wb_value    = 16'(wd);
    flush       = fl;
    #1;
    chk("alloc_ready", 32'(alloc_ready), 32'(m_count != 16));
    chk("alloc_index", 32'(alloc_index), 32'(m_tail()));
    chk("count", 32'(count), 32'(m_count));
    chk("wb_err", 32'(wb_err), 32'(m_err));
    $display("cyc t=%0t av=%0d ar=%0d wv=%0d wi=%0d wd=%04h fl=%0d cnt=%0d", $time, av, ar, wv, wi, wd, fl, m_count);
    model_step(av, ar, wv, wi, wd, fl);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 0;
    wb_valid = 0;
    flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every presented commit must match the oldest prediction
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_unexpected: got reg=%0d val=%04h, none expected", commit_reg, commit_value);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("commit reg=%0d val=%04h (want %0d/%04h)", commit_reg, commit_value, e.r, e.v);
        if (32'(commit_reg) !== 32'(e.r) || 32'(commit_value) !== 32'(e.v)) begin
          n_bad++;
          $display("FAIL commit_data: got reg=%0d val=%04h expected reg=%0d val=%04h",
                   commit_reg, commit_value, e.r, e.v);
        end
      end
    end
  end

  initial begin
    int pend[$];
    int wi;
    bit fl, wv;

    // Reset state
    do_reset();
    #1;
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commit_reg", 32'(commit_reg), 0);
    chk("rst_commit_value", 32'(commit_value), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_err", 32'(wb_err), 0);

    // Allocate 3,5,7 then complete out of order
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 'h00AA, 0);
    cyc(0, 0, 1, 0, 'h0011, 0);
    cyc(0, 0, 1, 2, 'h0022, 0);
    idle(5);

    // Fill to full from index 0, hold a request while full, then wrap
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, $urandom_range(15), 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 1, 0, 'h0BEE, 0);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_reg_slot0", 32'(m_reg[0]), 9);
    for (int i = 1; i < 16; i++) cyc(0, 0, 1, 16 - i, $urandom_range(16'hFFFF), 0);
    cyc(0, 0, 1, 0, 'h0909, 0);
    idle(20);
    chk("drain_count", 32'(count), 0);

    // Duplicate writeback keeps the first value and flags an error
    do_reset();
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 'h1234, 0);
    cyc(0, 0, 1, 0, 'h5678, 0);
    idle(3);

    // Writeback to a free entry while empty
    do_reset();
    cyc(0, 0, 1, 4, 'h4444, 0);
    idle(3);

    // Allocation on the same edge the head retires
    cyc(1, 6, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 'h0066, 0);
    cyc(1, 8, 0, 0, 0, 0);
    idle(2);

    // Flush with five busy, two done (not the head)
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, i + 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 'h0101, 0);
    cyc(0, 0, 1, 3, 'h0303, 0);
    cyc(1, 12, 0, 0, 0, 1);
    #1;
    chk("flush_commit_valid", 32'(commit_valid), 0);
    cyc(1, 10, 0, 0, 0, 0);
    idle(2);

    // Reset arriving while a commit is being presented
    cyc(0, 0, 1, 0, 'hCAFE, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_commit_valid", 32'(commit_valid), 0);
    chk("rstmid_commit_reg", 32'(commit_reg), 0);
    chk("rstmid_commit_value", 32'(commit_value), 0);
    chk("rstmid_count", 32'(count), 0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      pend.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i] && !m_done[i]) pend.push_back(i);
      fl = ($urandom_range(99) < 2);
      wv = !fl && ($urandom_range(99) < 55);
      if (pend.size() > 0 && $urandom_range(99) < 95)
        wi = pend[$urandom_range(pend.size() - 1)];
      else
        wi = $urandom_range(15);
      cyc($urandom_range(99) < 60, $urandom_range(15), wv, wi, $urandom_range(16'hFFFF), fl);
    end

    // Drain everything still outstanding
    for (int n = 0; n < 60; n++) begin
      pend.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i] && !m_done[i]) pend.push_back(i);
      if (pend.size() > 0) cyc(0, 0, 1, pend[0], $urandom_range(16'hFFFF), 0);
      else cyc(0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    #1;
    chk("final_pending_commits", 32'(exp_q.size()), 0);
    chk("final_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer that is the receiving end of the FXU completion interface.
- Allocates in-order entries at dispatch and hands each new entry's index to the issue path; that index returns with the FXU result.
- Captures FXU writebacks, which may arrive out of order, by index.
- Retires completed entries strictly in program order to the register file, one per cycle.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and equal to 2**IDX_W.
- IDX_W, 4, entry index width; matches the FXU rob index width.
- DATA_W, 16, result value width.
- REG_W, 4, architectural register number width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- alloc_valid  in  1  dispatch requests a new entry this cycle.
- alloc_reg  in  REG_W  destination register of the dispatched instruction.
- alloc_ready  out  1  entry available; combinational, equals (count != DEPTH).
- alloc_index  out  IDX_W  index the request is given; equals tail.
- wb_valid  in  1  FXU completion strobe.
- wb_index  in  IDX_W  entry being completed.
- wb_value  in  DATA_W  result value.
- flush  in  1  synchronous discard of all entries.
- commit_valid  out  1  registered; one retirement per asserted cycle.
- commit_reg  out  REG_W  registered destination of retired entry.
- commit_value  out  DATA_W  registered value of retired entry.
- count  out  IDX_W+1  occupied entries, 0..DEPTH.
- wb_err  out  1  sticky; set by an illegal writeback.

Behaviour:
- State:
  - Circular buffer with head pointer (oldest), tail pointer (next free) and count.
  - Each entry holds busy, done, reg and value.
- Reset (async, rst=1):
  - head=0, tail=0, count=0.
  - All busy and done flags cleared.
  - commit_valid=0, commit_reg=0, commit_value=0, wb_err=0.
  - Entry reg and value contents need not be cleared.
- Allocation: fires on an edge where alloc_valid && alloc_ready.
  - Entry[tail] gets busy=1, done=0, reg=alloc_reg.
  - tail increments mod DEPTH.
  - alloc_valid while full is ignored: no state change, no error.
- Writeback: on an edge where wb_valid, and entry[wb_index] has busy=1 and done=0.
  - value=wb_value, done=1.
  - Writeback to an entry that is not busy, or already done, is ignored and sets wb_err (cleared only by rst).
- Retirement: on each edge where count>0 and entry[head] has busy && done.
  - commit_valid<=1; commit_reg and commit_value loaded from entry[head].
  - entry[head].busy and .done cleared; head increments mod DEPTH.
  - Otherwise commit_valid<=0; commit_reg and commit_value hold their last value.
  - Latency: the earliest commit_valid is the cycle after the writeback edge. There is no writeback-to-commit bypass.
- Simultaneous events on one edge:
  - Allocation and retirement together: count unchanged, both pointers advance.
  - alloc_ready is computed from the current count only, so a full buffer cannot allocate on the same edge a retire frees a slot.
  - Writeback to the head entry on the same edge it is checked for retirement: not retired this edge; retires on the next.
  - Writeback and allocation targeting the same index cannot occur, since a free entry is not busy.
- Wrap-around:
  - Pointers wrap 15->0.
  - Full when count==DEPTH, with head==tail.
  - Empty when count==0, with head==tail.
- Flush (synchronous, highest priority below rst):
  - head=tail=0, count=0, all busy and done cleared, commit_valid<=0.
  - Same-edge alloc, writeback and retirement are discarded.
  - wb_err is unaffected.
- Reset asserted mid-operation clears everything immediately; an in-flight commit is lost.

Test Plan:
- Reset, then allocate regs 3,5,7 on consecutive cycles -> alloc_index 0,1,2; count=3; commit_valid stays 0.
- From that state, writeback idx1=0x00AA, then idx0=0x0011, then idx2=0x0022 -> commits in order (3,0x0011), (5,0x00AA), (7,0x0022) on three consecutive cycles; count=0.
- Allocate 16 entries -> alloc_ready=0, count=16. Hold alloc_valid with reg 9 -> no 17th entry. Write back idx0, let it retire, then allocate -> new entry at idx0, reg 9 (wrap).
- Writeback idx4 while empty -> wb_err=1, no commit. Duplicate writeback to an already-done entry also sets wb_err, and the first value is kept.
- Same edge: allocate plus retire of the head -> count unchanged, tail and head both advance.
- With 5 entries busy, 2 done: assert flush -> count=0, commit_valid=0 next cycle. Next allocation gets index 0. Assert rst during a commit -> all outputs 0 asynchronously.
